// File: rtl/timer_keypad_loader_pkg.sv
// Shared definitions for the cook-timer keypad blocks.
//   - Digit geometry (digit width, number of digit positions, buffer width).
//   - Key codes for CLEAR/STOP and START.
//   - Loader FSM state encoding.
//   - Helper that classifies a key code as a decimal digit.
package timer_keypad_loader_pkg;

    localparam int DIGIT_W = 4;                  // one BCD digit
    localparam int NDIGITS = 4;                  // MM:SS
    localparam int DATA_W  = DIGIT_W * NDIGITS;  // 16-bit load word
    localparam int CNT_W   = 3;                  // holds 0..NDIGITS

    localparam logic [DIGIT_W-1:0] KEY_CLEAR = 4'hA;
    localparam logic [DIGIT_W-1:0] KEY_START = 4'hB;

    typedef enum logic [1:0] {
        ST_ENTRY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // Codes 0-9 are digits; 10/11 are commands; 12-15 are unused keys.
    function automatic logic is_digit(input logic [DIGIT_W-1:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/timer_keypad_loader_key_edge.sv
// key_edge_detect
//   Turns a level "key held" signal into a single accept pulse on the first
//   clock edge of each press, so a held key is acted on exactly once.
// Ports
//   clk          in  system clock, rising edge
//   rst_n        in  asynchronous active-low reset
//   key_valid_i  in  high while a key is held (already debounced)
//   accept_o     out high during the cycle in which a new press is seen;
//                    the consumer acts on it at the next rising edge
module key_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic key_valid_i,
    output logic accept_o
);

    logic key_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_prev_q <= 1'b0;
        end else begin
            key_prev_q <= key_valid_i;
        end
    end

    // Feeds only registered state in the consumer, so no key input reaches
    // a module output combinationally.
    assign accept_o = key_valid_i & ~key_prev_q;

endmodule

// File: rtl/timer_keypad_loader.sv
// timer_keypad_loader
//   Keypad front end for the cook timer. Collects digit presses into a
//   4-digit shift buffer, issues a one-cycle load to the BCD down-counter
//   chain on START, then keeps the chain enabled until it reports 00:00
//   or the user presses CLEAR/STOP.
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   key_valid  in   high while a key is held
//   key_code   in   [3:0] 0-9 digit, 4'hA CLEAR, 4'hB START, 12-15 ignored
//   zero_L     in   low when the counter chain reads 00:00
//   load       out  one-cycle pulse, counters copy d_out
//   enablen    out  active-low count enable to the counter chain
//   d_out      out  [15:0] {min tens, min units, sec tens, sec units}
//   digit_cnt  out  [2:0] digits entered since last clear, saturates at 4
//   done       out  one-cycle pulse when the countdown reaches 00:00
// All outputs come straight from registers.
module timer_keypad_loader
    import timer_keypad_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    input  logic [DIGIT_W-1:0] key_code,
    input  logic              zero_L,
    output logic              load,
    output logic              enablen,
    output logic [DATA_W-1:0] d_out,
    output logic [CNT_W-1:0]  digit_cnt,
    output logic              done
);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   digits_q, digits_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                load_q, load_d;
    logic                enablen_q, enablen_d;
    logic                done_q, done_d;
    logic                run_first_q, run_first_d;

    logic                accept;
    logic [DATA_W-1:0]   digits_shifted;

    key_edge_detect u_key_edge (
        .clk         (clk),
        .rst_n       (rst),
        .key_valid_i (key_valid),
        .accept_o    (accept)
    );

    // New digit enters at the seconds-units end; the minutes-tens digit
    // falls off the top on a fifth entry.
    generate
        for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_shift
            if (gi == 0) begin : g_lsd
                assign digits_shifted[DIGIT_W-1:0] = key_code;
            end else begin : g_upper
                assign digits_shifted[gi*DIGIT_W +: DIGIT_W] =
                    digits_q[(gi-1)*DIGIT_W +: DIGIT_W];
            end
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        digits_d    = digits_q;
        cnt_d       = cnt_q;
        load_d      = 1'b0;
        done_d      = 1'b0;
        run_first_d = 1'b0;

        unique case (state_q)
            ST_ENTRY: begin
                if (accept) begin
                    if (is_digit(key_code)) begin
                        digits_d = digits_shifted;
                        if (cnt_q != CNT_W'(NDIGITS)) begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end else if (key_code == KEY_CLEAR) begin
                        digits_d = '0;
                        cnt_d    = '0;
                    end else if (key_code == KEY_START) begin
                        // Nothing to count down: leave START without effect.
                        if ((cnt_q != '0) && (digits_q != '0)) begin
                            state_d = ST_LOAD;
                            load_d  = 1'b1;
                        end
                    end
                end
            end

            ST_LOAD: begin
                // Keys pressed here are dropped; the edge detector still
                // tracks the key level so a held key is not replayed later.
                state_d     = ST_RUN;
                run_first_d = 1'b1;
            end

            ST_RUN: begin
                if (accept && (key_code == KEY_CLEAR)) begin
                    // STOP takes priority over a simultaneous terminal count.
                    state_d  = ST_ENTRY;
                    digits_d = '0;
                    cnt_d    = '0;
                end else if (!run_first_q && !zero_L) begin
                    // zero_L is not trusted in the first RUN cycle: the
                    // counters have only just taken the load.
                    state_d  = ST_ENTRY;
                    digits_d = '0;
                    cnt_d    = '0;
                    done_d   = 1'b1;
                end
            end

            default: begin
                state_d  = ST_ENTRY;
                digits_d = '0;
                cnt_d    = '0;
            end
        endcase

        enablen_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_ENTRY;
            digits_q    <= '0;
            cnt_q       <= '0;
            load_q      <= 1'b0;
            enablen_q   <= 1'b1;
            done_q      <= 1'b0;
            run_first_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            digits_q    <= digits_d;
            cnt_q       <= cnt_d;
            load_q      <= load_d;
            enablen_q   <= enablen_d;
            done_q      <= done_d;
            run_first_q <= run_first_d;
        end
    end

    assign load      = load_q;
    assign enablen   = enablen_q;
    assign d_out     = digits_q;
    assign digit_cnt = cnt_q;
    assign done      = done_q;

endmodule

// File: tb/tb_timer_keypad_loader.sv
// Self-checking bench for timer_keypad_loader: directed scenarios followed
// by random key/zero_L traffic, all compared against a digit-list model.
module tb_timer_keypad_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        zero_L;
    logic        load;
    logic        enablen;
    logic [15:0] d_out;
    logic [2:0]  digit_cnt;
    logic        done;

    int checks = 0;
    int errors = 0;

    // Reference model: entered digits newest-last, plus a coarse mode.
    int m_dig[4];        // m_dig[0] = seconds units
    int m_count;
    int m_mode;          // 0 = entry, 1 = loading, 2 = running
    int m_run_age;       // completed RUN cycles
    bit m_prev;
    bit m_done;

    timer_keypad_loader dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .zero_L    (zero_L),
        .load      (load),
        .enablen   (enablen),
        .d_out     (d_out),
        .digit_cnt (digit_cnt),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic int m_value();
        return m_dig[3] * 4096 + m_dig[2] * 256 + m_dig[1] * 16 + m_dig[0];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 4; i++) m_dig[i] = 0;
        m_count = 0; m_mode = 0; m_run_age = 0; m_prev = 0; m_done = 0;
    endtask

    task automatic m_clear();
        for (int i = 0; i < 4; i++) m_dig[i] = 0;
        m_count = 0;
    endtask

    // One rising edge of the timer, using the inputs present before it.
    task automatic m_edge(input bit kv, input int kc, input bit zl);
        bit acc;
        acc    = kv && !m_prev;
        m_prev = kv;
        m_done = 0;
        if (m_mode == 0) begin
            if (acc && kc <= 9) begin
                for (int i = 3; i > 0; i--) m_dig[i] = m_dig[i-1];
                m_dig[0] = kc;
                if (m_count < 4) m_count++;
            end else if (acc && kc == 10) begin
                m_clear();
            end else if (acc && kc == 11 && m_count != 0 && m_value() != 0) begin
                m_mode = 1;
            end
        end else if (m_mode == 1) begin
            m_mode = 2; m_run_age = 0;
        end else begin
            if (acc && kc == 10) begin
                m_clear(); m_mode = 0;
            end else if (m_run_age >= 1 && !zl) begin
                m_clear(); m_mode = 0; m_done = 1;
            end else begin
                m_run_age++;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".d_out"},     {16'd0, d_out},     32'(m_value()));
        chk({tag, ".digit_cnt"}, {29'd0, digit_cnt}, 32'(m_count));
        chk({tag, ".load"},      {31'd0, load},      32'(m_mode == 1));
        chk({tag, ".enablen"},   {31'd0, enablen},   32'(m_mode != 2));
        chk({tag, ".done"},      {31'd0, done},      32'(m_done));
    endtask

    // Called just after a falling edge: drive, clock, check at next falling edge.
    task automatic step(input string tag, input bit kv, input int kc, input bit zl);
        key_valid = kv; key_code = 4'(kc); zero_L = zl;
        @(posedge clk);
        m_edge(kv, kc, zl);
        @(negedge clk);
        chk_all(tag);
        $display("step %s kv=%0d key=%0d zl=%0d -> d_out=%h cnt=%0d load=%0d en_n=%0d done=%0d",
                 tag, kv, kc, zl, d_out, digit_cnt, load, enablen, done);
    endtask

    task automatic press(input string tag, input int kc, input int hold);
        for (int i = 0; i < hold; i++) step(tag, 1, kc, 1);
        step(tag, 0, kc, 1);
    endtask

    initial begin
        int hold;
        bit kv;
        int kc;
        bit zl;

        rst = 1'b0; key_valid = 1'b0; key_code = 4'd0; zero_L = 1'b1;
        m_reset();
        repeat (2) @(negedge clk);
        chk_all("reset");
        rst = 1'b1;

        // Digits shift in from the right.
        press("k1", 1, 1); press("k2", 2, 1); press("k3", 3, 1); press("k0", 0, 1);
        chk("d_out_1230", {16'd0, d_out}, 32'h1230);
        chk("cnt_4", {29'd0, digit_cnt}, 32'd4);

        // Fifth digit onward drops the oldest; a held key counts once.
        press("k9", 9, 1); press("k8", 8, 1); press("k7", 7, 1); press("k6", 6, 1);
        press("k5held", 5, 10);
        chk("d_out_8765", {16'd0, d_out}, 32'h8765);
        chk("cnt_sat", {29'd0, digit_cnt}, 32'd4);

        // 00:90 -> START -> load pulse -> RUN -> terminal count.
        press("clr", 10, 1);
        press("k9b", 9, 1); press("k0b", 0, 1);
        chk("d_out_0090", {16'd0, d_out}, 32'h0090);
        step("start", 1, 11, 1);
        chk("load_hi", {31'd0, load}, 32'd1);
        step("start_rel", 0, 11, 1);
        chk("load_lo", {31'd0, load}, 32'd0);
        chk("en_low", {31'd0, enablen}, 32'd0);
        press("run_k7", 7, 1);
        chk("run_d_hold", {16'd0, d_out}, 32'h0090);
        step("zero", 0, 0, 0);
        chk("zero_done", {31'd0, done}, 32'd1);
        chk("zero_en", {31'd0, enablen}, 32'd1);
        step("after_zero", 0, 0, 1);

        // START with nothing entered is ignored.
        press("start_empty", 11, 1);
        chk("empty_noload", {31'd0, load}, 32'd0);
        press("k0c", 0, 1);
        press("start_zero", 11, 1);
        chk("zero_val_noload", {31'd0, load}, 32'd0);

        // CLEAR and zero_L on the same edge: CLEAR wins, no done.
        press("k4", 4, 1);
        press("start2", 11, 1);
        step("run2", 0, 0, 1);
        step("clr_zero", 1, 10, 0);
        chk("clrzero_done", {31'd0, done}, 32'd0);
        chk("clrzero_en", {31'd0, enablen}, 32'd1);
        step("clr_rel", 0, 10, 1);

        // Asynchronous reset between edges while running.
        press("k3b", 3, 1);
        press("start3", 11, 1);
        step("run3", 0, 0, 1);
        chk("run3_en", {31'd0, enablen}, 32'd0);
        #1 rst = 1'b0;
        #1;
        m_reset();
        chk("arst_en", {31'd0, enablen}, 32'd1);
        chk("arst_d", {16'd0, d_out}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Random traffic.
        hold = 0; kv = 0; kc = 0;
        for (int i = 0; i < 800; i++) begin
            if (hold == 0) begin
                kv   = ($urandom_range(0, 1) == 1);
                kc   = ($urandom_range(0, 4) == 0) ? 11 : $urandom_range(0, 15);
                hold = $urandom_range(1, 4);
            end
            hold--;
            zl = ($urandom_range(0, 7) != 0);
            step("rand", kv, kc, zl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
